// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared bus widths, zip field offsets and load size codes for the pipeline stages
package pipe_pkg;

    localparam int ES2MS_BUS_W = 150;
    localparam int RF_ZIP_W    = 39;
    localparam int MEM_ZIP_W   = 5;

    // es2ms_bus / ms2ws_bus: {vaddr, csr_zip, except_zip, pc}
    localparam int BUS_PC_LO    = 0;
    localparam int BUS_EXC_LO   = 32;
    localparam int BUS_EXC_W    = 7;
    localparam int BUS_CSR_LO   = 39;
    localparam int BUS_VADDR_LO = 118;

    // rf zip: {csr_re, rf_we, rf_waddr, rf_wdata}
    localparam int RF_WDATA_LO   = 0;
    localparam int RF_WADDR_LO   = 32;
    localparam int RF_WE_BIT     = 37;
    localparam int RF_CSR_RE_BIT = 38;

    // mem zip: {mem_req, is_load, ld_unsigned, ld_size}
    localparam int MEM_SIZE_LO  = 0;
    localparam int MEM_UNS_BIT  = 2;
    localparam int MEM_LOAD_BIT = 3;
    localparam int MEM_REQ_BIT  = 4;

    localparam logic [1:0] LD_SIZE_B = 2'b00;
    localparam logic [1:0] LD_SIZE_H = 2'b01;
    localparam logic [1:0] LD_SIZE_W = 2'b10;

    // except_zip bit 0 is ertn, bits 6:1 are the exception causes
    localparam int EXC_ERTN_BIT  = 0;
    localparam int EXC_FIRST_BIT = 1;
    localparam int EXC_LAST_BIT  = 6;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data lane select and sign/zero extension
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword accesses are naturally aligned, so only addr_lo[1] picks the lane.
    assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    assign half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});

    always_comb begin
        result = rdata;
        case (size)
            LD_SIZE_B: result = {{24{~uns & byte_sel[7]}}, byte_sel};
            LD_SIZE_H: result = {{16{~uns & half_sel[15]}}, half_sel};
            LD_SIZE_W: result = rdata;
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: waits for data SRAM responses, aligns loads, drops flushed work
module mem_stage
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ms_allowin,
    input  logic                   es2ms_valid,
    input  logic [ES2MS_BUS_W-1:0] es2ms_bus,
    input  logic [RF_ZIP_W-1:0]    es_rf_zip,
    input  logic [MEM_ZIP_W-1:0]   es_mem_zip,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    output logic                   ms2ws_valid,
    output logic [ES2MS_BUS_W-1:0] ms2ws_bus,
    output logic [RF_ZIP_W-1:0]    ms_rf_zip,
    output logic                   ms_ex,
    input  logic                   ws_ex,
    input  logic                   ertn_flush
);

    logic                   ms_valid_q;
    logic [ES2MS_BUS_W-1:0] bus_q;
    logic [RF_ZIP_W-1:0]    rf_q;
    logic [MEM_ZIP_W-1:0]   mem_q;
    logic                   rdata_buf_valid_q;
    logic [31:0]            rdata_buf_q;
    logic [1:0]             drop_cnt_q;
    logic [1:0]             drop_cnt_d;

    logic        flush;
    logic        ms_mem_req;
    logic        ms_ready_go;
    logic        live_ok;
    logic        handoff;
    logic [31:0] ld_data;
    logic [31:0] ld_result;
    logic [1:0]  drop_inc;
    logic        drop_dec;
    logic [2:0]  drop_sum;

    assign flush       = ws_ex | ertn_flush;
    assign ms_mem_req  = mem_q[MEM_REQ_BIT];
    assign live_ok     = data_sram_data_ok & (drop_cnt_q == 2'd0);
    assign ms_ready_go = ~ms_mem_req | rdata_buf_valid_q | live_ok;
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid_q & ms_ready_go;
    assign handoff     = ms2ws_valid & ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
        end else if (flush) begin
            ms_valid_q <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_q <= es2ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q <= '0;
            rf_q  <= '0;
            mem_q <= '0;
        end else if (es2ms_valid & ms_allowin & ~flush) begin
            bus_q <= es2ms_bus;
            rf_q  <= es_rf_zip;
            mem_q <= es_mem_zip;
        end
    end

    // Holds a response that arrived while write-back was stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_valid_q <= 1'b0;
            rdata_buf_q       <= '0;
        end else if (flush | handoff) begin
            rdata_buf_valid_q <= 1'b0;
        end else if (live_ok & ms_valid_q & ms_mem_req & ~rdata_buf_valid_q) begin
            rdata_buf_valid_q <= 1'b1;
            rdata_buf_q       <= data_sram_rdata;
        end
    end

    // Responses still owed to flushed requests: the stalled one in this stage and the one issued from execute.
    always_comb begin
        drop_inc = 2'd0;
        if (flush) begin
            drop_inc = {1'b0, ms_valid_q & ms_mem_req & ~rdata_buf_valid_q & ~data_sram_data_ok}
                     + {1'b0, es2ms_valid & es_mem_zip[MEM_REQ_BIT]};
        end
        drop_dec   = data_sram_data_ok & (drop_cnt_q != 2'd0);
        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drop_inc} - {2'b00, drop_dec};
        drop_cnt_d = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 2'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ld_data = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

    load_align u_load_align (
        .rdata   (ld_data),
        .addr_lo (rf_q[RF_WDATA_LO +: 2]),
        .size    (mem_q[MEM_SIZE_LO +: 2]),
        .uns     (mem_q[MEM_UNS_BIT]),
        .result  (ld_result)
    );

    assign ms2ws_bus = bus_q;
    assign ms_rf_zip = {rf_q[RF_CSR_RE_BIT],
                        rf_q[RF_WE_BIT] & ms_valid_q,
                        rf_q[RF_WADDR_LO +: 5],
                        mem_q[MEM_LOAD_BIT] ? ld_result : rf_q[RF_WDATA_LO +: 32]};
    assign ms_ex     = ms_valid_q & (|bus_q[BUS_EXC_LO +: BUS_EXC_W]);

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized self-checking bench for mem_stage
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [149:0] es2ms_bus;
    logic [38:0]  es_rf_zip;
    logic [4:0]   es_mem_zip;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [149:0] ms2ws_bus;
    logic [38:0]  ms_rf_zip;
    logic         ms_ex;
    logic         ws_ex;
    logic         ertn_flush;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es2ms_valid       (es2ms_valid),
        .es2ms_bus         (es2ms_bus),
        .es_rf_zip         (es_rf_zip),
        .es_mem_zip        (es_mem_zip),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms2ws_valid       (ms2ws_valid),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_ex             (ms_ex),
        .ws_ex             (ws_ex),
        .ertn_flush        (ertn_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference load result: pick the addressed lane and extend by signedness.
    function automatic logic [31:0] ref_align(logic [31:0] d, logic [1:0] a, logic [1:0] sz, logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (sz)
            2'd0:    return uns ? 32'(b) : 32'($signed(b));
            2'd1:    return uns ? 32'(h) : 32'($signed(h));
            default: return d;
        endcase
    endfunction

    typedef struct {
        logic [149:0] bus;
        logic [38:0]  rf;
        logic [4:0]   mz;
        int           id;
        logic         got;
        logic [31:0]  rd;
    } insn_t;

    typedef struct {
        int          id;
        logic [31:0] rd;
    } resp_t;

    insn_t ex_i, mem_i;
    bit    ex_valid, mem_occ;
    resp_t rq[$];
    bit    orphan[int];
    int    n_orphan;
    int    next_id;

    task automatic idle();
        es2ms_valid       = 1'b0;
        es2ms_bus         = '0;
        es_rf_zip         = '0;
        es_mem_zip        = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        ws_ex             = 1'b0;
        ertn_flush        = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_allowin"}, ms_allowin, 1);
        check({tag, "_valid"}, ms2ws_valid, 0);
        check({tag, "_ex"}, ms_ex, 0);
        check({tag, "_rf"}, ms_rf_zip, 0);
        check({tag, "_bus"}, ms2ws_bus, 0);
        check({tag, "_drop"}, dut.drop_cnt_q, 0);
        check({tag, "_buf"}, dut.rdata_buf_valid_q, 0);
    endtask

    task automatic present_load(input logic [1:0] sz, input logic uns, input logic [1:0] a);
        es2ms_valid = 1'b1;
        es2ms_bus   = 150'({$urandom, $urandom, $urandom, $urandom, $urandom}) & ~(150'h7f << 32);
        es_rf_zip   = {1'b0, 1'b1, 5'd7, 30'h0123_4567, a};
        es_mem_zip  = {1'b1, 1'b1, uns, sz};
    endtask

    task automatic load_once(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [1:0] a, input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        present_load(sz, uns, a);
        @(posedge clk);
        @(negedge clk);
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        ws_allowin        = 1'b1;
        #1;
        check({tag, "_vld"}, ms2ws_valid, 1);
        check({tag, "_wdata"}, ms_rf_zip[31:0], exp);
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check({tag, "_one_cycle"}, ms2ws_valid, 0);
    endtask

    function automatic insn_t gen_insn();
        insn_t  t;
        logic   req;
        t.bus = 150'({$urandom, $urandom, $urandom, $urandom, $urandom});
        t.bus[38:32] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
        t.rf  = 39'({$urandom, $urandom});
        req   = ($urandom_range(0, 2) != 0);
        t.mz  = {req, req & 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2))};
        t.id  = 0;
        t.got = 1'b0;
        t.rd  = '0;
        return t;
    endfunction

    task automatic rand_cycle();
        logic        fl, dok, wsa, head_mine, go, exp_allowin;
        logic [31:0] rd;
        logic [38:0] exp_rf;
        resp_t       h;
        if (!ex_valid && $urandom_range(0, 2) != 0) begin
            ex_i     = gen_insn();
            ex_i.id  = next_id++;
            ex_valid = 1'b1;
            if (ex_i.mz[4]) rq.push_back('{ex_i.id, $urandom});
        end
        fl        = (n_orphan == 0) && ($urandom_range(0, 19) == 0);
        head_mine = (rq.size() > 0) && mem_occ && !mem_i.got && (rq[0].id == mem_i.id);
        dok       = !fl && (rq.size() > 0) && (orphan.exists(rq[0].id) || head_mine)
                    && ($urandom_range(0, 1) == 1);
        wsa       = ($urandom_range(0, 3) != 0);

        es2ms_valid       = ex_valid;
        es2ms_bus         = ex_i.bus;
        es_rf_zip         = ex_i.rf;
        es_mem_zip        = ex_i.mz;
        data_sram_data_ok = dok;
        data_sram_rdata   = dok ? rq[0].rd : $urandom;
        ws_allowin        = wsa;
        ws_ex             = fl & 1'($urandom);
        ertn_flush        = fl & ~ws_ex;
        #1;

        go          = mem_occ && (!mem_i.mz[4] || mem_i.got || (dok && head_mine));
        exp_allowin = !mem_occ || (go && wsa);
        check("r_valid", ms2ws_valid, go);
        check("r_allowin", ms_allowin, exp_allowin);
        check("r_ms_ex", ms_ex, mem_occ && (|mem_i.bus[38:32]));
        check("r_rf_we", ms_rf_zip[37], mem_occ && mem_i.rf[37]);
        if (go) begin
            rd     = mem_i.got ? mem_i.rd : rq[0].rd;
            exp_rf = mem_i.rf;
            if (mem_i.mz[3]) exp_rf[31:0] = ref_align(rd, mem_i.rf[1:0], mem_i.mz[1:0], mem_i.mz[2]);
            check("r_bus", ms2ws_bus, mem_i.bus);
            check("r_rf", ms_rf_zip, exp_rf);
        end

        @(posedge clk);
        if (dok) begin
            h = rq.pop_front();
            if (orphan.exists(h.id)) begin
                orphan.delete(h.id);
                n_orphan--;
            end else begin
                mem_i.got = 1'b1;
                mem_i.rd  = h.rd;
            end
        end
        if (fl) begin
            if (mem_occ && mem_i.mz[4] && !mem_i.got) begin
                orphan[mem_i.id] = 1'b1;
                n_orphan++;
            end
            if (ex_valid && ex_i.mz[4]) begin
                orphan[ex_i.id] = 1'b1;
                n_orphan++;
            end
            mem_occ  = 1'b0;
            ex_valid = 1'b0;
        end else begin
            if (go && wsa) mem_occ = 1'b0;
            if (exp_allowin && ex_valid) begin
                mem_i     = ex_i;
                mem_i.got = 1'b0;
                mem_occ   = 1'b1;
                ex_valid  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        load_once("lb_s",  2'd0, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80);
        load_once("lb_u",  2'd0, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080);
        load_once("lh_u",  2'd1, 1'b1, 2'd2, 32'h8001ABCD, 32'h00008001);
        load_once("lh_s0", 2'd1, 1'b0, 2'd0, 32'h8001ABCD, 32'hFFFFABCD);
        load_once("lw",    2'd2, 1'b0, 2'd0, 32'h8001ABCD, 32'h8001ABCD);

        // Flush with one load stalled here and another already requested from execute.
        @(negedge clk);
        present_load(2'd2, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        present_load(2'd2, 1'b0, 2'd0);
        #1;
        check("fl_stall_allowin", ms_allowin, 0);
        ws_ex = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        check("fl_valid", ms2ws_valid, 0);
        check("fl_allowin", ms_allowin, 1);
        check("fl_drop2", dut.drop_cnt_q, 2);
        for (int i = 0; i < 2; i++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = $urandom;
            #1;
            check("fl_orphan_no_valid", ms2ws_valid, 0);
            @(posedge clk);
            @(negedge clk);
            data_sram_data_ok = 1'b0;
        end
        #1;
        check("fl_drop0", dut.drop_cnt_q, 0);
        load_once("fl_next", 2'd0, 1'b0, 2'd1, 32'h1234F600, 32'hFFFFFFF6);

        // Reset while stalled on a missing response.
        @(negedge clk);
        present_load(2'd2, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        check("rs_stall_allowin", ms_allowin, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("rs_mid");
        @(negedge clk);
        reset = 1'b0;

        ex_valid = 1'b0;
        mem_occ  = 1'b0;
        n_orphan = 0;
        next_id  = 1;
        for (int c = 0; c < 4000; c++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
